// File: rtl/truth_table_capture.sv
// truth_table_capture
// Sweeps a 5-bit stimulus vector through all 32 values. After each vector
// change it waits SETTLE cycles, then captures the response f_in into a
// 32-bit truth table and keeps a running count of captured ones.
// The FSM runs IDLE -> (SETTLE ->) SAMPLE -> ... -> DONE -> IDLE.

module truth_table_capture #(
  parameter int SETTLE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_f_in,
  output logic [4:0]  o_vec,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_truth_table,
  output logic [5:0]  o_ones_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Reload value of the settle counter and the state entered after a
  // vector change; with SETTLE = 0 the settle phase is skipped entirely.
  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
  localparam logic [1:0] S_AFTER_LOAD = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [4:0]  r_vec;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_tt;
  logic [5:0]  r_ones;

  logic [1:0]  w_state_nxt;
  logic        w_vec_last;
  logic        w_settle_last;

  assign w_vec_last    = (r_vec == 5'd31);
  // Counter value 1 marks the final settle cycle; <= also recovers from 0.
  assign w_settle_last = (r_cnt <= 4'd1);

  // Next-state decode for the sweep sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_AFTER_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (w_settle_last) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_state_nxt = S_SETTLE;
        end
      end
      S_SAMPLE: begin
        if (w_vec_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_AFTER_LOAD;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs; reset dominates everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_vec   <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tt    <= 32'd0;
      r_ones  <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_vec  <= 5'd0;
            r_tt   <= 32'd0;
            r_ones <= 6'd0;
            r_cnt  <= SETTLE_CNT;
          end
        end
        S_SETTLE: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_SAMPLE: begin
          r_tt[r_vec] <= i_f_in;
          r_ones      <= r_ones + {5'd0, i_f_in};
          if (!w_vec_last) begin
            r_vec <= r_vec + 5'd1;
            r_cnt <= SETTLE_CNT;
          end
        end
        S_DONE: begin
          r_cnt <= 4'd0;
        end
        default: begin
          r_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign o_vec         = r_vec;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_truth_table = r_tt;
  assign o_ones_count  = r_ones;

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: three instances (SETTLE = 1, 0, 2) share
// clock and reset. Expected tables are pushed to a scoreboard queue when a
// sweep is started and popped when the instance raises done.

module tb_truth_table_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [3];
  logic        f_in  [3];
  logic [4:0]  vec   [3];
  logic        busy  [3];
  logic        done  [3];
  logic [31:0] tt    [3];
  logic [5:0]  ones  [3];

  int   mode;
  logic tog;
  int   n_checks = 0;
  int   n_pass   = 0;

  typedef struct {
    logic [31:0] tt;
    logic [5:0]  ones;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  truth_table_capture #(.SETTLE(1)) u_s1 (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_f_in(f_in[0]),
    .o_vec(vec[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_truth_table(tt[0]), .o_ones_count(ones[0]));

  truth_table_capture #(.SETTLE(0)) u_s0 (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_f_in(f_in[1]),
    .o_vec(vec[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_truth_table(tt[1]), .o_ones_count(ones[1]));

  truth_table_capture #(.SETTLE(2)) u_s2 (
    .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_f_in(f_in[2]),
    .o_vec(vec[2]), .o_busy(busy[2]), .o_done(done[2]),
    .o_truth_table(tt[2]), .o_ones_count(ones[2]));

  function automatic int settle_of(input int s);
    if (s == 0) return 1;
    else if (s == 1) return 0;
    else return 2;
  endfunction

  // Function under test: 0 = const 1, 1 = E, 2 = boolean expression,
  // 3 = externally toggled value (only meaningful outside SAMPLE).
  function automatic logic fmodel(input int m, input logic [4:0] v, input logic t);
    logic a, b, c, d, e;
    {a, b, c, d, e} = v;
    case (m)
      0:       return 1'b1;
      1:       return v[0];
      2:       return (a | ~b | c) & (~a | d) & (b | ~c | ~e);
      default: return t;
    endcase
  endfunction

  // Drive each instance's response from its own vector.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      f_in[i] = fmodel(mode, vec[i], tog);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push_exp(input int s, input int m);
    exp_t e;
    logic b;
    e.tt   = 32'd0;
    e.ones = 6'd0;
    e.lat  = 32 * (settle_of(s) + 1);
    for (int i = 0; i < 32; i++) begin
      b = (m == 3) ? 1'b0 : fmodel(m, 5'(i), 1'b0);
      e.tt[i] = b;
      e.ones  = e.ones + 6'(b);
    end
    sb.push_back(e);
  endtask

  // Called at the negedge right after the accepting edge (cycle k = 0).
  task automatic wait_done(input int s, input int m, input bit disturb, input bit post);
    exp_t e;
    int   k;
    bit   found = 1'b0;
    bit   pulsed = 1'b0;
    int   bound = 32 * (settle_of(s) + 1) + 8;
    for (k = 0; k <= bound; k++) begin
      if (m == 3) begin
        if (k % 3 == 2) tog = 1'b0;
        else if (k % 3 == 1) tog = 1'b1;
        else tog = 1'($urandom_range(0, 1));
      end else begin
        tog = 1'b0;
      end
      if (disturb) begin
        if (!pulsed && vec[s] == 5'd5) begin
          start[s] = 1'b1;
          pulsed = 1'b1;
        end else begin
          start[s] = 1'b0;
        end
      end
      if (done[s]) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found || sb.size() == 0) begin
      check("done_timeout", 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    check("done_latency", 32'(k), 32'(e.lat));
    check("truth_table", tt[s], e.tt);
    check("ones_count", 32'(ones[s]), 32'(e.ones));
    check("vec_end", 32'(vec[s]), 32'd31);
    check("busy_in_done", 32'(busy[s]), 32'd1);
    if (post) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        mode = 3;
        tog  = 1'($urandom_range(0, 1));
        check("done_single", 32'(done[s]), 32'd0);
        check("busy_idle", 32'(busy[s]), 32'd0);
        check("tt_hold", tt[s], e.tt);
        check("ones_hold", 32'(ones[s]), 32'(e.ones));
        check("vec_hold", 32'(vec[s]), 32'd31);
      end
    end
  endtask

  task automatic run_sweep(input int s, input int m, input bit disturb);
    @(negedge clk);
    mode     = m;
    start[s] = 1'b1;
    push_exp(s, m);
    @(negedge clk);
    start[s] = 1'b0;
    check("accept_busy", 32'(busy[s]), 32'd1);
    wait_done(s, m, disturb, 1'b1);
  endtask

  initial begin
    int   n;
    rst  = 1'b1;
    mode = 0;
    tog  = 1'b0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_vec", 32'(vec[i]), 32'd0);
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_done", 32'(done[i]), 32'd0);
      check("rst_tt", tt[i], 32'd0);
      check("rst_ones", 32'(ones[i]), 32'd0);
    end
    rst = 1'b0;

    // f_in tied high, SETTLE = 1
    run_sweep(0, 0, 1'b0);
    check("const1_tt", tt[0], 32'hFFFF_FFFF);
    check("const1_ones", 32'(ones[0]), 32'd32);

    // f_in = E, SETTLE = 0
    run_sweep(1, 1, 1'b0);
    check("vec0_tt", tt[1], 32'hAAAA_AAAA);
    check("vec0_ones", 32'(ones[1]), 32'd16);

    // boolean expression, SETTLE = 1
    run_sweep(0, 2, 1'b0);
    check("expr_tt", tt[0], 32'hCC4C_F05F);
    check("expr_ones", 32'(ones[0]), 32'd17);

    // f_in active only during settle cycles, SETTLE = 2
    run_sweep(2, 3, 1'b0);
    check("settle_tt", tt[2], 32'd0);
    check("settle_ones", 32'(ones[2]), 32'd0);

    // start re-pulsed at vec == 5 is ignored
    run_sweep(0, 2, 1'b1);
    check("repulse_tt", tt[0], 32'hCC4C_F05F);

    // reset in the middle of a sweep
    @(negedge clk);
    mode     = 1;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (vec[0] != 5'd10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_vec10", 32'(vec[0]), 32'd10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy[0]), 32'd0);
    check("midrst_done", 32'(done[0]), 32'd0);
    check("midrst_tt", tt[0], 32'd0);
    check("midrst_ones", 32'(ones[0]), 32'd0);
    check("midrst_vec", 32'(vec[0]), 32'd0);
    run_sweep(0, 1, 1'b0);

    // start on the same edge as reset is ignored
    @(negedge clk);
    rst      = 1'b1;
    start[2] = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    start[2] = 1'b0;
    check("rst_start_busy", 32'(busy[2]), 32'd0);
    @(negedge clk);
    check("rst_start_busy2", 32'(busy[2]), 32'd0);

    // start held high: new sweep begins from the IDLE cycle after DONE
    @(negedge clk);
    mode     = 0;
    start[1] = 1'b1;
    push_exp(1, 0);
    @(negedge clk);
    wait_done(1, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("hold_idle_busy", 32'(busy[1]), 32'd0);
    push_exp(1, 0);
    @(negedge clk);
    check("hold_restart_busy", 32'(busy[1]), 32'd1);
    start[1] = 1'b0;
    wait_done(1, 0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/truth_table_capture.md
TRUTH_TABLE_CAPTURE -- requirements
Module: truth_table_capture

Interface
REQ-001 Parameter: SETTLE, default 1, number of settle cycles between driving vec and sampling f_in (legal range 0..15).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin one exhaustive sweep; sampled only in IDLE.
REQ-005 f_in  input  1  response of the function under test to vec.
REQ-006 vec  output  5  stimulus vector {A,B,C,D,E}, A = bit 4 (MSB).
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse when the sweep completes.
REQ-009 truth_table  output  32  captured responses; bit i = f_in sampled while vec == i.
REQ-010 ones_count  output  6  number of 1s captured in the sweep, 0..32.

Function
REQ-011 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE.
REQ-012 In IDLE with start=1: vec<=0, truth_table<=0, ones_count<=0, settle counter<=SETTLE; next state SETTLE if SETTLE>0, else SAMPLE.
REQ-013 In IDLE with start=0: all outputs hold; done=0.
REQ-014 In SETTLE: counter decrements each cycle; vec holds; when the counter reaches 1 (final SETTLE cycle), next state is SAMPLE.
REQ-015 In SAMPLE: truth_table[vec]<=f_in and ones_count<=ones_count+f_in (6-bit, no overflow possible).
REQ-016 In SAMPLE with vec<31: vec<=vec+1, counter reloads SETTLE; next state SETTLE, or SAMPLE when SETTLE=0.
REQ-017 In SAMPLE with vec==31: vec holds at 31, no wrap; next state DONE.
REQ-018 In DONE: done=1 for exactly that cycle; next state IDLE unconditionally.
REQ-019 Each vector SHALL occupy SETTLE+1 cycles; done SHALL be high in the cycle following edge 32*(SETTLE+1) after the edge that accepted start.
REQ-020 start asserted while busy=1 SHALL be ignored, with no restart and no queuing.
REQ-021 start held high continuously SHALL begin a new sweep from the IDLE cycle after DONE.
REQ-022 After done, truth_table, ones_count and vec SHALL hold until the next accepted start or reset.
REQ-023 f_in SHALL be sampled only in SAMPLE; changes of f_in in SETTLE, IDLE and DONE SHALL have no effect.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, vec=0, busy=0, done=0, truth_table=0, ones_count=0 and settle counter=0.
REQ-025 rst SHALL take priority over start and over every state, including mid-sweep; partial results are discarded.
REQ-026 start asserted on the same edge as rst SHALL be ignored.

Verification
REQ-027 f_in tied 1, SETTLE=1, start pulse -> done high after edge 64, truth_table=0xFFFFFFFF, ones_count=32.
REQ-028 f_in=vec[0], SETTLE=0 -> done high after edge 32, truth_table=0xAAAAAAAA, ones_count=16.
REQ-029 f_in=(A|~B|C)&(~A|D)&(B|~C|~E) computed from vec, SETTLE=1 -> truth_table=0xCC4CF05F, ones_count=17.
REQ-030 rst pulsed while vec==10 mid-sweep -> next cycle IDLE, busy=0, truth_table=0, ones_count=0; a following start runs a full sweep correctly.
REQ-031 start re-pulsed at vec==5 -> ignored; single done; results match an undisturbed sweep.
REQ-032 f_in toggled only during SETTLE cycles (SETTLE=2), held 0 during SAMPLE -> truth_table=0, ones_count=0.
